// File: rtl/multiply_sequencer.sv
// Multi-cycle RV32M multiplier: four 16x16 partial products accumulated into a
// 64-bit register over four cycles, then sign-corrected and written to answer.
module multiply_sequencer #(
    parameter int XLEN       = 32,
    parameter bit EARLY_ZERO = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      funct,
    input  logic [XLEN-1:0] operator_1,
    input  logic [XLEN-1:0] operator_2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] answer
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_step;
    logic [63:0] r_acc;
    logic [31:0] r_mag_a;
    logic [31:0] r_mag_b;
    logic        r_neg;
    logic        r_hi_sel;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_answer;

    logic        w_sign_a;
    logic        w_sign_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_zero;
    logic [15:0] w_a_half;
    logic [15:0] w_b_half;
    logic [31:0] w_pp;
    logic [63:0] w_pp_shifted;
    logic [63:0] w_res;

    // Operand magnitudes from the live inputs; only used on the accepting edge.
    always_comb begin
        w_sign_a = operator_1[31] & ((funct == 2'b01) | (funct == 2'b10));
        w_sign_b = operator_2[31] & (funct == 2'b01);
        w_mag_a  = w_sign_a ? (32'd0 - operator_1) : operator_1;
        w_mag_b  = w_sign_b ? (32'd0 - operator_2) : operator_2;
        w_zero   = (w_mag_a == 32'd0) | (w_mag_b == 32'd0);
    end

    // One 16x16 product per step; step bit 0 picks A's half, bit 1 picks B's.
    always_comb begin
        w_a_half = r_step[0] ? r_mag_a[31:16] : r_mag_a[15:0];
        w_b_half = r_step[1] ? r_mag_b[31:16] : r_mag_b[15:0];
        w_pp     = w_a_half * w_b_half;
        case (r_step)
            2'd0:    w_pp_shifted = {32'd0, w_pp};
            2'd1:    w_pp_shifted = {16'd0, w_pp, 16'd0};
            2'd2:    w_pp_shifted = {16'd0, w_pp, 16'd0};
            2'd3:    w_pp_shifted = {w_pp, 32'd0};
            default: w_pp_shifted = 64'd0;
        endcase
        w_res = r_neg ? (64'd0 - r_acc) : r_acc;
    end

    // Sequencer FSM with registered busy/done/answer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_step   <= 2'd0;
            r_acc    <= 64'd0;
            r_mag_a  <= 32'd0;
            r_mag_b  <= 32'd0;
            r_neg    <= 1'b0;
            r_hi_sel <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_answer <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mag_a  <= w_mag_a;
                        r_mag_b  <= w_mag_b;
                        r_neg    <= w_sign_a ^ w_sign_b;
                        r_hi_sel <= (funct != 2'b00);
                        r_acc    <= 64'd0;
                        r_step   <= 2'd0;
                        r_busy   <= 1'b1;
                        r_state  <= (EARLY_ZERO && w_zero) ? S_FIX : S_MUL;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_acc <= r_acc + w_pp_shifted;
                    if (r_step == 2'd3) begin
                        r_state <= S_FIX;
                    end else begin
                        r_step <= r_step + 2'd1;
                    end
                end
                S_FIX: begin
                    r_answer <= r_hi_sel ? w_res[63:32] : w_res[31:0];
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign answer = r_answer;

endmodule
